// File: rtl/fc_neuron_seq.sv
// fc_neuron_seq: time-multiplexed fully-connected neuron.
// Streams LANES activation/weight pairs per beat and accumulates the
// dot product over BEATS beats, then adds a bias and applies the activation.
// Build option: define FC_NEURON_SEQ_RELU_EN to clamp negative results to 0;
// otherwise the raw signed sum is presented on z.
//
// state  | meaning
// ACCUM  | accepting beats, accumulating the running dot product
// OUT    | result held on z, waiting for out_ready
module fc_neuron_seq #(
  parameter int WIDTH = 8,
  parameter int IN    = 400,
  parameter int LANES = 4,
  localparam int BEATS = (IN + LANES - 1) / LANES,
  localparam int ACC_W = 2*WIDTH + $clog2(IN) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]   x,
  input  logic [LANES-1:0][WIDTH-1:0]   w,
  input  logic [2*WIDTH-1:0]            bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       z
);

  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  typedef enum logic {ST_ACCUM, ST_OUT} state_t;

  state_t                    state_q, state_d;
  logic [BCW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                      pvalid_q, last_q;
  logic signed [2*WIDTH-1:0] prod_q [LANES];
  logic signed [2*WIDTH-1:0] prod_d [LANES];
  logic signed [2*WIDTH-1:0] bias_q;
  logic signed [ACC_W-1:0]   acc_q, psum, fin_sum, z_d, z_q;
  logic                      accept, last_beat, fin;

  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign fin       = pvalid_q && last_q;
  assign accept    = in_valid && in_ready && !clr;
  assign beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
  assign z         = z_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACCUM;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; clr overrides everything.
  // With a single beat per frame a new beat could collide with the pending
  // result write, so in_ready also waits for the finish edge in that case.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = !rst && !((BEATS == 1) && fin);
        if (fin) state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
    if (clr) state_d = ST_ACCUM;
  end

  // Lane products; lanes past the last real input are zeroed on the final beat
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (last_beat && (int'(beat_cnt_q) * LANES + l >= IN))
        prod_d[l] = '0;
      else
        prod_d[l] = (2*WIDTH)'($signed(x[l])) * (2*WIDTH)'($signed(w[l]));
    end
  end

  // Lane sum, final sum with bias, and activation
  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++) psum = psum + ACC_W'(prod_q[l]);
    fin_sum = acc_q + psum + ACC_W'(bias_q);
`ifdef FC_NEURON_SEQ_RELU_EN
    z_d = fin_sum[ACC_W-1] ? '0 : fin_sum;
`else
    z_d = fin_sum;
`endif
  end

  // Product stage, accumulator and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      pvalid_q   <= 1'b0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      bias_q     <= '0;
      z_q        <= '0;
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
    end else if (clr) begin
      beat_cnt_q <= '0;
      pvalid_q   <= 1'b0;
      last_q     <= 1'b0;
      acc_q      <= '0;
    end else begin
      pvalid_q <= accept;
      last_q   <= accept && last_beat;
      if (accept) begin
        beat_cnt_q <= beat_cnt_d;
        for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
        if (last_beat) bias_q <= bias;
      end
      if (fin) begin
        z_q   <= z_d;
        acc_q <= '0;
      end else if (pvalid_q) begin
        acc_q <= acc_q + psum;
      end
    end
  end

endmodule
